// File: rtl/i2c_target_burst_if.sv
// ----------------------------------------------------------------------------
// i2c_target_burst_if
// Bus bundle between the board-side I2C pins / register file and the
// i2c_target_burst target.
//   assigned_address_i : 7-bit bus address the target answers to
//   scl_i / sda_i      : raw SCL pin and the input side of SDA
//   sda_oe_o           : 1 = pull SDA low, 0 = release (open-drain)
//   rd_addr_o/rd_data_i: register pointer and the register contents at it
//   wr_addr_o/wr_data_o/wr_en_o : register write port (one-cycle strobe)
//   busy_o             : target is currently addressed
//   dbg_state_o        : current FSM state encoding
// Modports: slave = the target, master = whatever drives the pins / regfile.
// ----------------------------------------------------------------------------
interface i2c_target_burst_if #(
  parameter int ADDR_W = 8
);
  logic [6:0]        assigned_address_i;
  logic              scl_i;
  logic              sda_i;
  logic              sda_oe_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [7:0]        rd_data_i;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [7:0]        wr_data_o;
  logic              wr_en_o;
  logic              busy_o;
  logic [3:0]        dbg_state_o;

  modport slave (
    input  assigned_address_i, scl_i, sda_i, rd_data_i,
    output sda_oe_o, rd_addr_o, wr_addr_o, wr_data_o, wr_en_o, busy_o, dbg_state_o
  );

  modport master (
    output assigned_address_i, scl_i, sda_i, rd_data_i,
    input  sda_oe_o, rd_addr_o, wr_addr_o, wr_data_o, wr_en_o, busy_o, dbg_state_o
  );
endinterface

// File: rtl/i2c_target_burst.sv
// ----------------------------------------------------------------------------
// i2c_target_burst
// I2C target with burst read/write, an auto-incrementing register pointer
// that wraps at REG_COUNT-1, repeated-START support and NACK of register ids
// that are out of range.
// Ports:
//   clk_i  : system clock, everything on posedge
//   rst_ni : synchronous active-low reset
//   bus    : i2c_target_burst_if.slave (pins, register-file ports, status)
//
// Register-file handshake: wr_en_o is a single-cycle strobe that qualifies
// wr_addr_o/wr_data_o; there is no back-pressure, the register file must
// accept the write in that cycle. rd_addr_o always shows the pointer and
// rd_data_i must reflect it within SYNC_STAGES clocks of a change; it is
// only sampled on the scl fall that starts each read byte.
// ----------------------------------------------------------------------------
module i2c_target_burst #(
  parameter int REG_COUNT   = 256,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  i2c_target_burst_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_ADDR_ACK = 4'd2,
    S_REG      = 4'd3,
    S_REG_ACK  = 4'd4,
    S_NACK     = 4'd5,
    S_WRITE    = 4'd6,
    S_WR_ACK   = 4'd7,
    S_READ     = 4'd8,
    S_RD_ACK   = 4'd9,
    S_IGNORE   = 4'd10
  } state_t;

  // Input synchronisers plus one-cycle-delayed copies for edge detection.
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  state_t            r_state,   w_state_n;
  logic [3:0]        r_cnt,     w_cnt_n;
  logic [6:0]        r_shift,   w_shift_n;
  logic [ADDR_W-1:0] r_ptr,     w_ptr_n;
  logic              r_rw,      w_rw_n;
  logic              r_sda_oe,  w_sda_oe_n;
  logic              r_busy,    w_busy_n;
  logic              r_wr_en,   w_wr_en_n;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_n;
  logic [7:0]        r_wr_data, w_wr_data_n;

  logic              w_scl;
  logic              w_sda;
  logic              w_rise;
  logic              w_fall;
  logic              w_start;
  logic              w_stop;
  logic [7:0]        w_byte;
  logic              w_addr_match;
  logic              w_id_ok;
  logic [ADDR_W-1:0] w_ptr_inc;

  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  // START/STOP require scl high on both samples so an sda change that races
  // an scl edge is never mistaken for a bus condition.
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;

  // Byte completed by the bit being sampled this cycle (MSB first).
  assign w_byte       = {r_shift, w_sda};
  assign w_addr_match = (r_shift == bus.assigned_address_i);
  assign w_id_ok      = ({24'd0, w_byte} < $unsigned(REG_COUNT));
  assign w_ptr_inc    = (r_ptr == ADDR_W'(REG_COUNT - 1)) ? '0 : r_ptr + ADDR_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_shift    <= w_shift_n;
      r_ptr      <= w_ptr_n;
      r_rw       <= w_rw_n;
      r_sda_oe   <= w_sda_oe_n;
      r_busy     <= w_busy_n;
      r_wr_en    <= w_wr_en_n;
      r_wr_addr  <= w_wr_addr_n;
      r_wr_data  <= w_wr_data_n;
    end
  end

  // In the ACK states the counter marks the phase: 8 = waiting for the fall
  // that opens the ACK bit, 9 = inside the ACK bit until the fall closing it.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_shift_n   = r_shift;
    w_ptr_n     = r_ptr;
    w_rw_n      = r_rw;
    w_sda_oe_n  = r_sda_oe;
    w_busy_n    = r_busy;
    w_wr_en_n   = 1'b0;
    w_wr_addr_n = r_wr_addr;
    w_wr_data_n = r_wr_data;

    if (w_stop) begin
      w_state_n  = S_IDLE;
      w_cnt_n    = '0;
      w_sda_oe_n = 1'b0;
      w_busy_n   = 1'b0;
    end else if (w_start) begin
      // Repeated START keeps the pointer so a write phase can set it for a read.
      w_state_n  = S_ADDR;
      w_cnt_n    = '0;
      w_sda_oe_n = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;

        S_ADDR: if (w_rise) begin
          w_shift_n = w_byte[6:0];
          w_cnt_n   = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_cnt_n = 4'd8;
            w_rw_n  = w_sda;
            if (w_addr_match) begin
              w_state_n = S_ADDR_ACK;
              w_busy_n  = 1'b1;
            end else begin
              w_state_n = S_IGNORE;
              w_busy_n  = 1'b0;
            end
          end
        end

        S_REG: if (w_rise) begin
          w_shift_n = w_byte[6:0];
          w_cnt_n   = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_cnt_n = 4'd8;
            if (w_id_ok) begin
              w_ptr_n   = w_byte[ADDR_W-1:0];
              w_state_n = S_REG_ACK;
            end else begin
              w_state_n = S_NACK;
              w_busy_n  = 1'b0;
            end
          end
        end

        S_WRITE: if (w_rise) begin
          w_shift_n = w_byte[6:0];
          w_cnt_n   = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_cnt_n     = 4'd8;
            w_wr_en_n   = 1'b1;
            w_wr_addr_n = r_ptr;
            w_wr_data_n = w_byte;
            w_ptr_n     = w_ptr_inc;
            w_state_n   = S_WR_ACK;
          end
        end

        S_ADDR_ACK, S_REG_ACK, S_WR_ACK, S_NACK: if (w_fall) begin
          if (r_cnt == 4'd8) begin
            w_cnt_n    = 4'd9;
            w_sda_oe_n = (r_state != S_NACK);
          end else begin
            w_cnt_n    = '0;
            w_sda_oe_n = 1'b0;
            if (r_state == S_NACK) begin
              w_state_n = S_IGNORE;
            end else if (r_state == S_ADDR_ACK && r_rw) begin
              // First read byte: bit7 goes out now, the rest wait in the shifter.
              w_state_n  = S_READ;
              w_shift_n  = bus.rd_data_i[6:0];
              w_sda_oe_n = ~bus.rd_data_i[7];
            end else if (r_state == S_ADDR_ACK) begin
              w_state_n = S_REG;
            end else begin
              w_state_n = S_WRITE;
            end
          end
        end

        S_READ: begin
          if (w_rise) begin
            w_cnt_n = r_cnt + 4'd1;
          end else if (w_fall) begin
            if (r_cnt == 4'd8) begin
              w_cnt_n    = '0;
              w_sda_oe_n = 1'b0;
              w_state_n  = S_RD_ACK;
            end else begin
              w_sda_oe_n = ~r_shift[6];
              w_shift_n  = {r_shift[5:0], 1'b0};
            end
          end
        end

        S_RD_ACK: begin
          if (w_rise) begin
            if (w_sda) begin
              w_state_n = S_IGNORE;
              w_busy_n  = 1'b0;
            end else begin
              w_ptr_n = w_ptr_inc;
            end
          end else if (w_fall) begin
            w_state_n  = S_READ;
            w_cnt_n    = '0;
            w_shift_n  = bus.rd_data_i[6:0];
            w_sda_oe_n = ~bus.rd_data_i[7];
          end
        end

        S_IGNORE: ;

        default: w_state_n = S_IDLE;
      endcase
    end
  end

  assign bus.sda_oe_o    = r_sda_oe;
  assign bus.rd_addr_o   = r_ptr;
  assign bus.wr_addr_o   = r_wr_addr;
  assign bus.wr_data_o   = r_wr_data;
  assign bus.wr_en_o     = r_wr_en;
  assign bus.busy_o      = r_busy;
  assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_i2c_target_burst.sv
// ----------------------------------------------------------------------------
// tb_i2c_target_burst
// Two targets: dut_a (REG_COUNT=256) and dut_b (REG_COUNT=16), both at 0x40.
// The bench plays the I2C controller on an open-drain (wired-AND) SDA line
// and models the register file read data as a fixed function of the address.
// ----------------------------------------------------------------------------
module tb_i2c_target_burst;
  localparam int Q = 8;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_ni;

  i2c_target_burst_if #(.ADDR_W(8)) bus_a ();
  i2c_target_burst_if #(.ADDR_W(8)) bus_b ();

  logic m_scl [2];
  logic m_sda [2];
  int   cur;

  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return (a * 8'd3) ^ 8'h5A;
  endfunction

  assign bus_a.assigned_address_i = 7'h40;
  assign bus_a.scl_i              = m_scl[0];
  assign bus_a.sda_i              = m_sda[0] & ~bus_a.sda_oe_o;
  assign bus_a.rd_data_i          = mem_f(bus_a.rd_addr_o);
  assign bus_b.assigned_address_i = 7'h40;
  assign bus_b.scl_i              = m_scl[1];
  assign bus_b.sda_i              = m_sda[1] & ~bus_b.sda_oe_o;
  assign bus_b.rd_data_i          = mem_f(bus_b.rd_addr_o);

  i2c_target_burst #(.REG_COUNT(256), .ADDR_W(8), .SYNC_STAGES(2)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_a)
  );
  i2c_target_burst #(.REG_COUNT(16), .ADDR_W(8), .SYNC_STAGES(2)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_b)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q   [$];
  logic [15:0] exp_b_q [$];
  logic [15:0] exp_w_a, exp_w_b;
  logic        oe_seen_a, oe_seen_b;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (bus_a.sda_oe_o) oe_seen_a = 1'b1;
    if (bus_b.sda_oe_o) oe_seen_b = 1'b1;
    if (rst_ni && bus_a.wr_en_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_a: unexpected write addr=%0h data=%0h", bus_a.wr_addr_o, bus_a.wr_data_o);
      end else begin
        exp_w_a = exp_q.pop_front();
        if ({bus_a.wr_addr_o, bus_a.wr_data_o} !== exp_w_a) begin
          errors++;
          $display("FAIL wr_a: got %0h expected %0h", {bus_a.wr_addr_o, bus_a.wr_data_o}, exp_w_a);
        end
      end
    end
    if (rst_ni && bus_b.wr_en_o) begin
      checks++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL wr_b: unexpected write addr=%0h data=%0h", bus_b.wr_addr_o, bus_b.wr_data_o);
      end else begin
        exp_w_b = exp_b_q.pop_front();
        if ({bus_b.wr_addr_o, bus_b.wr_data_o} !== exp_w_b) begin
          errors++;
          $display("FAIL wr_b: got %0h expected %0h", {bus_b.wr_addr_o, bus_b.wr_data_o}, exp_w_b);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic line_sda();
    return (cur == 0) ? bus_a.sda_i : bus_b.sda_i;
  endfunction

  task automatic wait_q();
    repeat (Q) @(negedge clk_i);
  endtask

  task automatic i2c_start();
    m_sda[cur] = 1'b1; wait_q();
    m_scl[cur] = 1'b1; wait_q();
    m_sda[cur] = 1'b0; wait_q();
    m_scl[cur] = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda[cur] = 1'b0; wait_q();
    m_scl[cur] = 1'b1; wait_q();
    m_sda[cur] = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda[cur] = b;    wait_q();
    m_scl[cur] = 1'b1; wait_q(); wait_q();
    m_scl[cur] = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda[cur] = 1'b1; wait_q();
    m_scl[cur] = 1'b1; wait_q();
    b = line_sda();    wait_q();
    m_scl[cur] = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
    m_sda[cur] = 1'b1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [6:0] addr;
    logic [7:0] id;
    logic [7:0] data;
    logic       a_ack;
    logic       i_ack;
    logic       d_ack;
  } vec_t;

  vec_t vecs [6];

  initial begin : main
    logic       ack;
    logic [7:0] rd;
    logic [7:0] exp_ptr;
    int         wait_cnt;

    vecs[0] = '{7'h40, 8'h05, 8'hA5, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{7'h40, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{7'h40, 8'hFF, 8'h81, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{7'h41, 8'h05, 8'h77, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{7'h00, 8'h10, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{7'h40, 8'h80, 8'hC3, 1'b1, 1'b1, 1'b1};

    cur = 0;
    m_scl[0] = 1'b1; m_sda[0] = 1'b1; m_scl[1] = 1'b1; m_sda[1] = 1'b1;
    oe_seen_a = 1'b0; oe_seen_b = 1'b0;
    rst_ni = 1'b0;
    repeat (5) @(negedge clk_i);
    check("rst_oe",      32'(bus_a.sda_oe_o),  32'(1'b0));
    check("rst_busy",    32'(bus_a.busy_o),    32'(1'b0));
    check("rst_wr_en",   32'(bus_a.wr_en_o),   32'(1'b0));
    check("rst_wr_addr", 32'(bus_a.wr_addr_o), 32'(8'h00));
    check("rst_wr_data", 32'(bus_a.wr_data_o), 32'(8'h00));
    check("rst_ptr",     32'(bus_a.rd_addr_o), 32'(8'h00));
    check("rst_oe_b",    32'(bus_b.sda_oe_o),  32'(1'b0));
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    exp_ptr = 8'h00;

    // single-byte write transactions from the table
    for (int v = 0; v < 6; v++) begin
      oe_seen_a = 1'b0;
      i2c_start();
      send_byte({vecs[v].addr, 1'b0}, ack);
      check("vec_addr_ack", 32'(ack), 32'(vecs[v].a_ack));
      send_byte(vecs[v].id, ack);
      check("vec_id_ack", 32'(ack), 32'(vecs[v].i_ack));
      if (vecs[v].d_ack) begin
        exp_q.push_back({vecs[v].id, vecs[v].data});
        exp_ptr = vecs[v].id + 8'd1;
      end
      send_byte(vecs[v].data, ack);
      check("vec_data_ack", 32'(ack), 32'(vecs[v].d_ack));
      i2c_stop();
      repeat (4) @(negedge clk_i);
      check("vec_busy", 32'(bus_a.busy_o), 32'(1'b0));
      check("vec_ptr", 32'(bus_a.rd_addr_o), 32'(exp_ptr));
      check("vec_wr_count", 32'(exp_q.size()), 32'(0));
      if (!vecs[v].a_ack) check("vec_oe_released", 32'(oe_seen_a), 32'(1'b0));
    end

    // burst write with wrap at 0xFF
    i2c_start();
    send_byte({7'h40, 1'b0}, ack); check("burst_addr_ack", 32'(ack), 32'(1'b1));
    send_byte(8'hFE, ack);         check("burst_id_ack",   32'(ack), 32'(1'b1));
    exp_q.push_back(16'hFE11); send_byte(8'h11, ack); check("burst_d0_ack", 32'(ack), 32'(1'b1));
    exp_q.push_back(16'hFF22); send_byte(8'h22, ack); check("burst_d1_ack", 32'(ack), 32'(1'b1));
    exp_q.push_back(16'h0033); send_byte(8'h33, ack); check("burst_d2_ack", 32'(ack), 32'(1'b1));
    i2c_stop();
    repeat (4) @(negedge clk_i);
    check("burst_ptr", 32'(bus_a.rd_addr_o), 32'(8'h01));
    check("burst_wr_count", 32'(exp_q.size()), 32'(0));

    // set pointer, repeated START, burst read ACK/ACK/NACK
    i2c_start();
    send_byte({7'h40, 1'b0}, ack); check("rd_waddr_ack", 32'(ack), 32'(1'b1));
    send_byte(8'h10, ack);         check("rd_id_ack",    32'(ack), 32'(1'b1));
    check("rd_ptr_set", 32'(bus_a.rd_addr_o), 32'(8'h10));
    i2c_start();
    send_byte({7'h40, 1'b1}, ack); check("rd_raddr_ack", 32'(ack), 32'(1'b1));
    check("rd_busy", 32'(bus_a.busy_o), 32'(1'b1));
    read_byte(1'b1, rd); check("rd_byte0", 32'(rd), 32'(mem_f(8'h10)));
    read_byte(1'b1, rd); check("rd_byte1", 32'(rd), 32'(mem_f(8'h11)));
    read_byte(1'b0, rd); check("rd_byte2", 32'(rd), 32'(mem_f(8'h12)));
    check("rd_busy_after_nack", 32'(bus_a.busy_o), 32'(1'b0));
    oe_seen_a = 1'b0;
    read_byte(1'b0, rd); check("rd_after_nack", 32'(rd), 32'(8'hFF));
    check("rd_oe_after_nack", 32'(oe_seen_a), 32'(1'b0));
    i2c_stop();
    check("rd_ptr_end", 32'(bus_a.rd_addr_o), 32'(8'h12));

    // STOP in the middle of a data byte: no write, no advance
    i2c_start();
    send_byte({7'h40, 1'b0}, ack); check("part_addr_ack", 32'(ack), 32'(1'b1));
    send_byte(8'h30, ack);         check("part_id_ack",   32'(ack), 32'(1'b1));
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    i2c_stop();
    repeat (4) @(negedge clk_i);
    check("part_ptr", 32'(bus_a.rd_addr_o), 32'(8'h30));

    // REG_COUNT=16 target: out-of-range id, then in-range burst with wrap at 15
    cur = 1;
    oe_seen_b = 1'b0;
    i2c_start();
    send_byte({7'h40, 1'b0}, ack); check("b_addr_ack", 32'(ack), 32'(1'b1));
    oe_seen_b = 1'b0;
    send_byte(8'h20, ack);         check("b_bad_id_nack", 32'(ack), 32'(1'b0));
    send_byte(8'h99, ack);         check("b_data_nack",   32'(ack), 32'(1'b0));
    check("b_oe_after_nack", 32'(oe_seen_b), 32'(1'b0));
    i2c_stop();
    repeat (4) @(negedge clk_i);
    check("b_ptr_kept", 32'(bus_b.rd_addr_o), 32'(8'h00));
    i2c_start();
    send_byte({7'h40, 1'b0}, ack); check("b2_addr_ack", 32'(ack), 32'(1'b1));
    send_byte(8'h0F, ack);         check("b2_id_ack",   32'(ack), 32'(1'b1));
    exp_b_q.push_back(16'h0F44); send_byte(8'h44, ack); check("b2_d0_ack", 32'(ack), 32'(1'b1));
    exp_b_q.push_back(16'h0055); send_byte(8'h55, ack); check("b2_d1_ack", 32'(ack), 32'(1'b1));
    i2c_stop();
    repeat (4) @(negedge clk_i);
    check("b2_ptr", 32'(bus_b.rd_addr_o), 32'(8'h01));
    check("b2_wr_count", 32'(exp_b_q.size()), 32'(0));

    // reset while the address ACK is being driven low
    cur = 0;
    i2c_start();
    for (int i = 7; i >= 1; i--) send_bit(((7'h40 >> (i - 1)) & 7'h01) != 7'h00);
    send_bit(1'b0);
    m_sda[0] = 1'b1;
    wait_q();
    m_scl[0] = 1'b1;
    wait_cnt = 0;
    while (!bus_a.sda_oe_o && wait_cnt < 50) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    check("rst_ack_driven", 32'(bus_a.sda_oe_o), 32'(1'b1));
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    check("rst_mid_oe", 32'(bus_a.sda_oe_o), 32'(1'b0));
    check("rst_mid_busy", 32'(bus_a.busy_o), 32'(1'b0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_q();
    m_scl[0] = 1'b0;
    wait_q();
    i2c_stop();
    check("rst_mid_ptr", 32'(bus_a.rd_addr_o), 32'(8'h00));
    i2c_start();
    send_byte({7'h40, 1'b0}, ack); check("post_addr_ack", 32'(ack), 32'(1'b1));
    send_byte(8'h22, ack);         check("post_id_ack",   32'(ack), 32'(1'b1));
    exp_q.push_back(16'h226E); send_byte(8'h6E, ack); check("post_data_ack", 32'(ack), 32'(1'b1));
    i2c_stop();
    repeat (4) @(negedge clk_i);
    check("post_ptr", 32'(bus_a.rd_addr_o), 32'(8'h23));

    // ---------------- final report ----------------
    check("final_exp_q_empty",   32'(exp_q.size()),   32'(0));
    check("final_exp_b_q_empty", 32'(exp_b_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
